// File: rtl/fft_frame_sequencer.sv
// fft_frame_sequencer: frames one 1024-point FFT transaction
// (clear, load, wait, clear, unload, done) around the address counter.
module fft_frame_sequencer #(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int TO_WIDTH       = 13
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       start,
    input  logic       continuous,
    input  logic       sample_valid,
    input  logic       fft_done,
    input  logic       fft_dv,
    input  logic       tc_counter,
    output logic       sclr_counter,
    output logic       en_counter,
    output logic       fft_start,
    output logic       fft_unload,
    output logic       busy,
    output logic       frame_done,
    output logic       err_timeout,
    output logic       err_overrun,
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        CLR_LOAD   = 3'd1,
        LOAD       = 3'd2,
        WAIT_DONE  = 3'd3,
        CLR_UNLOAD = 3'd4,
        UNLOAD     = 3'd5,
        DONE       = 3'd6
    } state_t;

    localparam logic [TO_WIDTH-1:0] TO_LAST = TO_WIDTH'(TIMEOUT_CYCLES - 1);

    state_t              state;
    state_t              state_nx;
    logic [TO_WIDTH-1:0] to_cnt;
    logic                to_hit;
    logic                ovr_hit;
    logic                clr_err;

    // Next-state decode plus error set/clear strobes.
    always_comb begin
        state_nx = state;
        to_hit   = 1'b0;
        ovr_hit  = 1'b0;
        clr_err  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = CLR_LOAD;
                    clr_err  = 1'b1;
                end
            end
            CLR_LOAD: begin
                ovr_hit  = sample_valid;
                state_nx = LOAD;
            end
            LOAD: begin
                if (sample_valid && tc_counter)
                    state_nx = WAIT_DONE;
            end
            WAIT_DONE: begin
                ovr_hit = sample_valid;
                if (fft_done) begin
                    state_nx = CLR_UNLOAD;
                end else if (to_cnt == TO_LAST) begin
                    to_hit   = 1'b1;
                    state_nx = IDLE;
                end
            end
            CLR_UNLOAD: begin
                ovr_hit  = sample_valid;
                state_nx = UNLOAD;
            end
            UNLOAD: begin
                ovr_hit = sample_valid;
                if (fft_dv && tc_counter)
                    state_nx = DONE;
            end
            DONE: begin
                ovr_hit  = sample_valid;
                state_nx = continuous ? CLR_LOAD : IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign sclr_counter = (state == CLR_LOAD) || (state == CLR_UNLOAD);
    assign en_counter   = ((state == LOAD) && sample_valid) ||
                          ((state == UNLOAD) && fft_dv);
    assign busy         = (state != IDLE);
    assign state_dbg    = state;

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    // Pulses registered from the next state so they align with that state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fft_start  <= 1'b0;
            fft_unload <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            fft_start  <= (state_nx == CLR_LOAD);
            fft_unload <= (state_nx == CLR_UNLOAD);
            frame_done <= (state_nx == DONE);
        end
    end

    // Timeout counter runs only in WAIT_DONE and sits at zero elsewhere.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)                to_cnt <= '0;
        else if (state == WAIT_DONE) to_cnt <= to_cnt + TO_WIDTH'(1);
        else                         to_cnt <= '0;
    end

    // Sticky error flags, cleared only by a fresh start from IDLE.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            err_timeout <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            if (clr_err)     err_timeout <= 1'b0;
            else if (to_hit) err_timeout <= 1'b1;
            if (clr_err)      err_overrun <= 1'b0;
            else if (ovr_hit) err_overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// tb_fft_frame_sequencer: directed checks of the FFT frame sequencer
// with a behavioural 10-bit address counter.
module tb_fft_frame_sequencer;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic       continuous = 1'b0;
    logic       sample_valid = 1'b0;
    logic       fft_done = 1'b0;
    logic       fft_dv = 1'b0;
    logic       tc_counter;
    logic       sclr_counter;
    logic       en_counter;
    logic       fft_start;
    logic       fft_unload;
    logic       busy;
    logic       frame_done;
    logic       err_timeout;
    logic       err_overrun;
    logic [2:0] state_dbg;

    logic [9:0] addr;
    int n_cmp = 0;
    int n_bad = 0;
    int cnt_en = 0;
    int cnt_fs = 0;
    int cnt_fu = 0;
    int cnt_fd = 0;

    fft_frame_sequencer dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start),
        .continuous  (continuous),
        .sample_valid(sample_valid),
        .fft_done    (fft_done),
        .fft_dv      (fft_dv),
        .tc_counter  (tc_counter),
        .sclr_counter(sclr_counter),
        .en_counter  (en_counter),
        .fft_start   (fft_start),
        .fft_unload  (fft_unload),
        .busy        (busy),
        .frame_done  (frame_done),
        .err_timeout (err_timeout),
        .err_overrun (err_overrun),
        .state_dbg   (state_dbg)
    );

    always #5 clock = ~clock;

    // Behavioural address counter driven by the sequencer.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n)          addr <= 10'd0;
        else if (sclr_counter) addr <= 10'd0;
        else if (en_counter)   addr <= addr + 10'd1;
    end
    assign tc_counter = (addr == 10'd1023);

    // Pulse/enable tallies taken mid-cycle.
    always @(negedge clock) begin
        if (reset_n) begin
            cnt_en = cnt_en + int'(en_counter);
            cnt_fs = cnt_fs + int'(fft_start);
            cnt_fu = cnt_fu + int'(fft_unload);
            cnt_fd = cnt_fd + int'(frame_done);
        end
    end

    // Start a new cycle and drop all pulse-type inputs.
    task automatic cyc();
        @(posedge clock);
        #1;
        start = 1'b0;
        sample_valid = 1'b0;
        fft_done = 1'b0;
        fft_dv = 1'b0;
    endtask

    task automatic do_reset();
        continuous = 1'b0;
        reset_n = 1'b0;
        repeat (3) cyc();
        reset_n = 1'b1;
        repeat (2) cyc();
    endtask

    // Leaves the current cycle as CLR_LOAD.
    task automatic begin_frame();
        cyc();
        start = 1'b1;
        cyc();
    endtask

    task automatic load_samples();
        for (int i = 0; i < 1024; i++) begin
            cyc();
            sample_valid = 1'b1;
        end
    endtask

    task automatic unload_bins();
        for (int i = 0; i < 1024; i++) begin
            cyc();
            fft_dv = 1'b1;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) cyc();
        @(negedge clock);
        if (state_dbg !== 3'd0) begin n_bad++; $display("FAIL rst_state got %0d want 0", state_dbg); end n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got %0b want 0", busy); end n_cmp++;
        reset_n = 1'b1;
        repeat (10) cyc();
        @(negedge clock);
        if (state_dbg !== 3'd0) begin n_bad++; $display("FAIL idle_state got %0d want 0", state_dbg); end n_cmp++;
        if ({sclr_counter, en_counter, fft_start, fft_unload, busy, frame_done, err_timeout, err_overrun} !== 8'h00) begin
            n_bad++;
            $display("FAIL idle_outs got %b want 00000000",
                     {sclr_counter, en_counter, fft_start, fft_unload, busy, frame_done, err_timeout, err_overrun});
        end
        n_cmp++;
    endtask

    task automatic test_nominal();
        int en0, fs0, fu0, fd0;
        cyc();
        en0 = cnt_en; fs0 = cnt_fs; fu0 = cnt_fu; fd0 = cnt_fd;
        start = 1'b1;
        cyc();
        @(negedge clock);
        if (state_dbg !== 3'd1) begin n_bad++; $display("FAIL nom_clr_state got %0d want 1", state_dbg); end n_cmp++;
        if ({fft_start, sclr_counter, busy} !== 3'b111) begin n_bad++; $display("FAIL nom_clr_outs got %b want 111", {fft_start, sclr_counter, busy}); end n_cmp++;
        load_samples();
        @(negedge clock);
        if ({state_dbg, tc_counter, en_counter} !== 5'b010_1_1) begin n_bad++; $display("FAIL nom_last_load got %b want 01011", {state_dbg, tc_counter, en_counter}); end n_cmp++;
        repeat (49) cyc();
        cyc();
        fft_done = 1'b1;
        @(negedge clock);
        if (state_dbg !== 3'd3) begin n_bad++; $display("FAIL nom_wait_state got %0d want 3", state_dbg); end n_cmp++;
        cyc();
        @(negedge clock);
        if ({state_dbg, fft_unload, sclr_counter} !== 5'b100_1_1) begin n_bad++; $display("FAIL nom_clr_unload got %b want 10011", {state_dbg, fft_unload, sclr_counter}); end n_cmp++;
        unload_bins();
        @(negedge clock);
        if ({state_dbg, tc_counter} !== 4'b101_1) begin n_bad++; $display("FAIL nom_last_bin got %b want 1011", {state_dbg, tc_counter}); end n_cmp++;
        cyc();
        @(negedge clock);
        if ({state_dbg, frame_done, busy} !== 5'b110_1_1) begin n_bad++; $display("FAIL nom_done got %b want 11011", {state_dbg, frame_done, busy}); end n_cmp++;
        cyc();
        @(negedge clock);
        if ({state_dbg, frame_done, busy} !== 5'b000_0_0) begin n_bad++; $display("FAIL nom_idle got %b want 00000", {state_dbg, frame_done, busy}); end n_cmp++;
        cyc();
        if (cnt_en - en0 !== 2048) begin n_bad++; $display("FAIL nom_en_count got %0d want 2048", cnt_en - en0); end n_cmp++;
        if (cnt_fs - fs0 !== 1) begin n_bad++; $display("FAIL nom_fs_count got %0d want 1", cnt_fs - fs0); end n_cmp++;
        if (cnt_fu - fu0 !== 1) begin n_bad++; $display("FAIL nom_fu_count got %0d want 1", cnt_fu - fu0); end n_cmp++;
        if (cnt_fd - fd0 !== 1) begin n_bad++; $display("FAIL nom_fd_count got %0d want 1", cnt_fd - fd0); end n_cmp++;
    endtask

    task automatic test_gapped();
        int acc, en0, early;
        do_reset();
        acc = 0;
        early = 0;
        en0 = cnt_en;
        begin_frame();
        for (int j = 0; j < 3300 && acc < 1024; j++) begin
            cyc();
            sample_valid = (j % 3 == 2);
            if (sample_valid) acc++;
            @(negedge clock);
            if (state_dbg != 3'd2) early++;
        end
        if (acc !== 1024) begin n_bad++; $display("FAIL gap_accepts got %0d want 1024", acc); end n_cmp++;
        if (early !== 0) begin n_bad++; $display("FAIL gap_left_load got %0d want 0", early); end n_cmp++;
        if (tc_counter !== 1'b1) begin n_bad++; $display("FAIL gap_tc got %0b want 1", tc_counter); end n_cmp++;
        cyc();
        @(negedge clock);
        if (state_dbg !== 3'd3) begin n_bad++; $display("FAIL gap_wait got %0d want 3", state_dbg); end n_cmp++;
        cyc();
        if (cnt_en - en0 !== 1024) begin n_bad++; $display("FAIL gap_en_count got %0d want 1024", cnt_en - en0); end n_cmp++;
    endtask

    task automatic test_timeout();
        int fd0;
        do_reset();
        fd0 = cnt_fd;
        begin_frame();
        load_samples();
        for (int i = 1; i <= 4096; i++) cyc();
        @(negedge clock);
        if ({state_dbg, err_timeout} !== 4'b011_0) begin n_bad++; $display("FAIL to_last_wait got %b want 0110", {state_dbg, err_timeout}); end n_cmp++;
        cyc();
        @(negedge clock);
        if ({state_dbg, err_timeout, busy} !== 5'b000_1_0) begin n_bad++; $display("FAIL to_abort got %b want 00010", {state_dbg, err_timeout, busy}); end n_cmp++;
        cyc();
        if (cnt_fd - fd0 !== 0) begin n_bad++; $display("FAIL to_no_done got %0d want 0", cnt_fd - fd0); end n_cmp++;
        start = 1'b1;
        cyc();
        @(negedge clock);
        if ({state_dbg, err_timeout} !== 4'b001_0) begin n_bad++; $display("FAIL to_clear got %b want 0010", {state_dbg, err_timeout}); end n_cmp++;
    endtask

    task automatic test_overrun();
        do_reset();
        cyc();
        sample_valid = 1'b1;
        cyc();
        @(negedge clock);
        if ({state_dbg, err_overrun} !== 4'b000_0) begin n_bad++; $display("FAIL ovr_idle got %b want 0000", {state_dbg, err_overrun}); end n_cmp++;
        cyc();
        start = 1'b1;
        cyc();
        sample_valid = 1'b1;
        @(negedge clock);
        if ({state_dbg, en_counter, err_overrun} !== 5'b001_0_0) begin n_bad++; $display("FAIL ovr_clr got %b want 00100", {state_dbg, en_counter, err_overrun}); end n_cmp++;
        cyc();
        @(negedge clock);
        if ({state_dbg, err_overrun} !== 4'b010_1) begin n_bad++; $display("FAIL ovr_flag got %b want 0101", {state_dbg, err_overrun}); end n_cmp++;
    endtask

    task automatic test_boundary();
        do_reset();
        begin_frame();
        load_samples();
        for (int i = 1; i <= 4096; i++) begin
            cyc();
            if (i == 4096) fft_done = 1'b1;
        end
        cyc();
        @(negedge clock);
        if ({state_dbg, err_timeout, fft_unload} !== 5'b100_0_1) begin n_bad++; $display("FAIL bnd_done_wins got %b want 10001", {state_dbg, err_timeout, fft_unload}); end n_cmp++;
    endtask

    task automatic test_back_to_back();
        int fd0;
        do_reset();
        fd0 = cnt_fd;
        continuous = 1'b1;
        begin_frame();
        load_samples();
        cyc();
        fft_done = 1'b1;
        cyc();
        unload_bins();
        cyc();
        @(negedge clock);
        if ({state_dbg, frame_done} !== 4'b110_1) begin n_bad++; $display("FAIL b2b_u1 got %b want 1101", {state_dbg, frame_done}); end n_cmp++;
        cyc();
        @(negedge clock);
        if ({state_dbg, fft_start, frame_done} !== 5'b001_1_0) begin n_bad++; $display("FAIL b2b_u2 got %b want 00110", {state_dbg, fft_start, frame_done}); end n_cmp++;
        load_samples();
        cyc();
        fft_done = 1'b1;
        cyc();
        unload_bins();
        cyc();
        continuous = 1'b0;
        cyc();
        @(negedge clock);
        if ({state_dbg, busy} !== 4'b000_0) begin n_bad++; $display("FAIL b2b_end got %b want 0000", {state_dbg, busy}); end n_cmp++;
        cyc();
        if (cnt_fd - fd0 !== 2) begin n_bad++; $display("FAIL b2b_fd_count got %0d want 2", cnt_fd - fd0); end n_cmp++;
    endtask

    task automatic test_mid_reset();
        int fd0;
        do_reset();
        fd0 = cnt_fd;
        begin_frame();
        for (int i = 0; i < 500; i++) begin
            cyc();
            sample_valid = 1'b1;
        end
        cyc();
        sample_valid = 1'b1;
        @(negedge clock);
        if ({state_dbg, addr} !== {3'd2, 10'd500}) begin n_bad++; $display("FAIL mid_addr got %0d/%0d want 2/500", state_dbg, addr); end n_cmp++;
        reset_n = 1'b0;
        #1;
        if (state_dbg !== 3'd0) begin n_bad++; $display("FAIL mid_state got %0d want 0", state_dbg); end n_cmp++;
        if ({sclr_counter, en_counter, fft_start, fft_unload, busy, frame_done, err_timeout, err_overrun} !== 8'h00) begin
            n_bad++;
            $display("FAIL mid_outs got %b want 00000000",
                     {sclr_counter, en_counter, fft_start, fft_unload, busy, frame_done, err_timeout, err_overrun});
        end
        n_cmp++;
        repeat (2) cyc();
        reset_n = 1'b1;
        repeat (3) cyc();
        if (cnt_fd - fd0 !== 0) begin n_bad++; $display("FAIL mid_no_done got %0d want 0", cnt_fd - fd0); end n_cmp++;
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_gapped();
        test_timeout();
        test_overrun();
        test_boundary();
        test_back_to_back();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fft_frame_sequencer.md
# fft_frame_sequencer

Control FSM that drives the FFT address counter's `sclr_counter`/`en_counter` pair and uses its `tc_counter` to frame one 1024-point FFT transaction. The sequence is: clear counter, load 1024 samples, wait for the transform, clear counter, unload 1024 bins, signal frame completion. It sits directly upstream of the FFT address datapath and handshakes with the FFT core and the sample source of the energy detection chain.

## Interface
- `TIMEOUT_CYCLES`, default 4096: maximum cycles spent in WAIT_DONE before aborting.
- `TO_WIDTH`, default 13: width of the timeout counter. It must satisfy 2^TO_WIDTH > TIMEOUT_CYCLES.
- `clock` in 1: single system clock. All logic is on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: level. Sampled only in IDLE.
- `continuous` in 1: when 1, DONE returns to CLR_LOAD instead of IDLE.
- `sample_valid` in 1: input sample present this cycle.
- `fft_done` in 1: one-cycle pulse from the FFT core, transform finished.
- `fft_dv` in 1: FFT output bin valid this cycle.
- `tc_counter` in 1: terminal count from the address counter (addr == 1023).
- `sclr_counter` out 1: synchronous clear to the address counter.
- `en_counter` out 1: count enable to the address counter.
- `fft_start` out 1: one-cycle pulse to the FFT core.
- `fft_unload` out 1: one-cycle pulse requesting bin unload.
- `busy` out 1: high in every state except IDLE.
- `frame_done` out 1: one-cycle pulse when a frame has fully unloaded.
- `err_timeout` out 1: sticky flag, set when WAIT_DONE times out.
- `err_overrun` out 1: sticky flag, set when `sample_valid` arrives while a sample cannot be accepted.
- `state_dbg` out 3: current state encoding.

## Operation
- State encodings: IDLE=0, CLR_LOAD=1, LOAD=2, WAIT_DONE=3, CLR_UNLOAD=4, UNLOAD=5, DONE=6. Code 7 is illegal and goes to IDLE.
- IDLE: on `start`=1, go to CLR_LOAD and clear both sticky error flags in the same edge.
- CLR_LOAD: one cycle. Go to LOAD.
- LOAD:
  - Each cycle with `sample_valid`=1 is one accepted sample.
  - `sample_valid & tc_counter` means the 1024th sample was accepted. Go to WAIT_DONE.
- WAIT_DONE:
  - The timeout counter increments every cycle.
  - `fft_done`=1: go to CLR_UNLOAD.
  - Counter reaches TIMEOUT_CYCLES-1 without `fft_done`: set `err_timeout` and go to IDLE.
  - If `fft_done` and timeout coincide, `fft_done` wins.
- CLR_UNLOAD: one cycle. Go to UNLOAD.
- UNLOAD: `fft_dv & tc_counter` goes to DONE.
- DONE: one cycle. Go to CLR_LOAD if `continuous`=1, else IDLE. Error flags are not cleared on the continuous path.
- `sclr_counter` is combinational: 1 in CLR_LOAD and CLR_UNLOAD.
- `en_counter` is combinational: (LOAD & `sample_valid`) | (UNLOAD & `fft_dv`).
- `fft_start` is registered. It is 1 during the CLR_LOAD cycle, so it is coincident with the counter clear.
- `fft_unload` is registered. It is 1 during the CLR_UNLOAD cycle.
- `frame_done` is registered. It is 1 during the DONE cycle.
- `err_overrun` is set when `sample_valid`=1 in CLR_LOAD, WAIT_DONE, CLR_UNLOAD, UNLOAD or DONE. Samples in IDLE are ignored silently.
- `tc_counter` outside LOAD/UNLOAD has no effect.
- `fft_done` outside WAIT_DONE is ignored.
- The timeout counter is zeroed on every entry to WAIT_DONE.

## Timing
- Reset (`reset_n`=0, asynchronous):
  - State goes to IDLE.
  - All registered outputs go to 0 and the timeout counter to 0.
  - Combinational outputs `sclr_counter` and `en_counter` resolve to 0.
  - Reset mid-frame abandons the frame with no `frame_done`.
- Deassertion is taken synchronously by the first rising edge after `reset_n` returns high.
- `start` sampled high at edge k:
  - Cycle k+1 is CLR_LOAD.
  - The earliest accepted sample is in cycle k+2.
- With `sample_valid` held high, LOAD lasts exactly 1024 cycles. The counter advances 0→1023, and `tc_counter` is high in the 1024th cycle.
- `fft_done` at cycle d: CLR_UNLOAD at d+1, UNLOAD from d+2.
- Last bin with `fft_dv & tc_counter` at cycle u: `frame_done`=1 at u+1.
- In continuous mode, CLR_LOAD follows at u+2, with no idle cycle.
- A gapped `sample_valid` or `fft_dv` stalls the counter but does not change state.

## Test plan
- Reset then idle: `reset_n` low for 3 cycles, then high for 10 cycles with `start`=0 → all outputs 0, `state_dbg`=0.
- Nominal frame with a behavioural 10-bit counter:
  - Stimulus: `start` one cycle, 1024 contiguous `sample_valid`, `fft_done` 50 cycles later, 1024 contiguous `fft_dv`.
  - Response: exactly 2048 `en_counter` cycles, one pulse each of `fft_start`, `fft_unload` and `frame_done`, `busy` then drops.
- Gapped input: `sample_valid` asserted every 3rd cycle → 1024 accepts, and WAIT_DONE entered only on the accept where `tc_counter`=1.
- Timeout: no `fft_done` for 4096 cycles in WAIT_DONE → `err_timeout`=1, return to IDLE, no `frame_done`. The next `start` clears the flag.
- Overrun and boundary:
  - `sample_valid` high in CLR_LOAD → `err_overrun`=1.
  - `fft_done` coincident with the final timeout cycle → CLR_UNLOAD is taken and `err_timeout` stays 0.
- Continuous mode plus mid-frame reset:
  - `continuous`=1 over 2 frames → `frame_done` at u+1, `fft_start` at u+2.
  - `reset_n` asserted at LOAD addr 500 → immediate IDLE with all outputs 0.
